// File: rtl/frame_loader_if.sv
// frame_loader_if: host byte stream, frame control and LED row-buffer write port
//   master side (host/bench): drives frame_start, byte_in, byte_valid
//   slave side (frame_loader): drives byte_ready, row_data, row/panel address,
//   row_data_write_enable, busy, frame_done, frame_abort
interface frame_loader_if #(
    parameter int BYTES_PER_ROW  = 48,
    parameter int ROWS_PER_PANEL = 16,
    parameter int PANELS         = 4
);
    logic                              frame_start;
    logic [7:0]                        byte_in;
    logic                              byte_valid;
    logic                              byte_ready;
    logic [8*BYTES_PER_ROW-1:0]        row_data;
    logic [$clog2(ROWS_PER_PANEL)-1:0] row_data_row_addr;
    logic [$clog2(PANELS)-1:0]         row_data_panel_addr;
    logic                              row_data_write_enable;
    logic                              busy;
    logic                              frame_done;
    logic                              frame_abort;

    modport master (
        output frame_start, byte_in, byte_valid,
        input  byte_ready, row_data, row_data_row_addr, row_data_panel_addr,
               row_data_write_enable, busy, frame_done, frame_abort
    );

    modport slave (
        input  frame_start, byte_in, byte_valid,
        output byte_ready, row_data, row_data_row_addr, row_data_panel_addr,
               row_data_write_enable, busy, frame_done, frame_abort
    );
endinterface

// File: rtl/frame_loader.sv
// frame_loader: assembles host bytes into rows and writes them panel-major into the LED row buffers
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : frame_loader_if.slave (byte stream in, row write port and frame status out)
module frame_loader #(
    parameter int BYTES_PER_ROW  = 48,
    parameter int ROWS_PER_PANEL = 16,
    parameter int PANELS         = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    frame_loader_if.slave bus
);
    localparam int CW = $clog2(BYTES_PER_ROW);
    localparam int RW = $clog2(ROWS_PER_PANEL);
    localparam int PW = $clog2(PANELS);
    localparam int DW = 8 * BYTES_PER_ROW;
    localparam logic [CW-1:0] CNT_LAST   = CW'(BYTES_PER_ROW - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS_PER_PANEL - 1);
    localparam logic [PW-1:0] PANEL_LAST = PW'(PANELS - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          ready_q;
    logic          accept;
    logic          last_row;
    logic          last_write;

    // frame_start wins over a byte offered in the same cycle, so ready drops with it
    assign bus.byte_ready = ready_q & ~bus.frame_start;
    assign accept         = bus.byte_valid & bus.byte_ready;
    assign last_row       = bus.row_data_row_addr == ROW_LAST;
    assign last_write     = last_row && bus.row_data_panel_addr == PANEL_LAST;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                     <= IDLE;
            cnt                       <= '0;
            ready_q                   <= 1'b0;
            bus.row_data              <= '0;
            bus.row_data_row_addr     <= '0;
            bus.row_data_panel_addr   <= '0;
            bus.row_data_write_enable <= 1'b0;
            bus.busy                  <= 1'b0;
            bus.frame_done            <= 1'b0;
            bus.frame_abort           <= 1'b0;
        end else begin
            bus.row_data_write_enable <= 1'b0;
            bus.frame_done            <= 1'b0;
            bus.frame_abort           <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.frame_start) begin
                        state                   <= COLLECT;
                        cnt                     <= '0;
                        ready_q                 <= 1'b1;
                        bus.busy                <= 1'b1;
                        bus.row_data_row_addr   <= '0;
                        bus.row_data_panel_addr <= '0;
                    end
                end
                COLLECT: begin
                    if (bus.frame_start) begin
                        cnt                     <= '0;
                        bus.row_data_row_addr   <= '0;
                        bus.row_data_panel_addr <= '0;
                        bus.frame_abort         <= 1'b1;
                    end else if (accept) begin
                        bus.row_data <= {bus.row_data[DW-9:0], bus.byte_in};
                        if (cnt == CNT_LAST) begin
                            cnt                       <= '0;
                            state                     <= WRITE;
                            ready_q                   <= 1'b0;
                            bus.row_data_write_enable <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (bus.frame_start) begin
                        // a restart landing on the final write is a clean new frame, not an abort
                        state                   <= COLLECT;
                        ready_q                 <= 1'b1;
                        bus.row_data_row_addr   <= '0;
                        bus.row_data_panel_addr <= '0;
                        bus.frame_abort         <= ~last_write;
                    end else if (last_write) begin
                        state                   <= IDLE;
                        bus.busy                <= 1'b0;
                        bus.frame_done          <= 1'b1;
                        bus.row_data_row_addr   <= '0;
                        bus.row_data_panel_addr <= '0;
                    end else begin
                        state                 <= COLLECT;
                        ready_q               <= 1'b1;
                        bus.row_data_row_addr <= last_row ? '0 : bus.row_data_row_addr + 1'b1;
                        if (last_row)
                            bus.row_data_panel_addr <= bus.row_data_panel_addr + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_loader.sv
// tb_frame_loader: directed self-checking bench for frame_loader
module tb_frame_loader;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    frame_loader_if bus ();
    frame_loader dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [5:0]   log_addr [0:1023];
    logic [383:0] log_data [0:1023];
    int           log_cyc  [0:1023];
    int nw = 0, ndone = 0, nabort = 0, done_cyc = 0, viol = 0;

    always @(negedge clk) begin
        if (bus.row_data_write_enable) begin
            log_addr[nw] = {bus.row_data_panel_addr, bus.row_data_row_addr};
            log_data[nw] = bus.row_data;
            log_cyc[nw]  = cyc;
            nw = nw + 1;
        end
        if (bus.frame_done) begin
            ndone = ndone + 1;
            done_cyc = cyc;
        end
        if (bus.frame_abort) nabort = nabort + 1;
        if (bus.byte_ready && (bus.row_data_write_enable || !bus.busy)) viol = viol + 1;
    end

    function automatic logic [383:0] exp_row(input int first);
        logic [383:0] r;
        for (int j = 0; j < 48; j++) r[383-8*j -: 8] = 8'(first + j);
        return r;
    endfunction

    task automatic do_reset();
        bus.frame_start = 1'b0;
        bus.byte_valid  = 1'b0;
        bus.byte_in     = 8'h00;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic start_frame();
        @(negedge clk);
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
    endtask

    task automatic send_bytes(input int n, input int first, input int duty);
        int k = 0;
        int budget = 40 * n + 100;
        while (k < n && budget > 0) begin
            @(negedge clk);
            bus.byte_valid = ($urandom_range(99) < duty);
            bus.byte_in = 8'(first + k);
            #1;
            if (bus.byte_valid && bus.byte_ready) k++;
            budget--;
        end
        tests++;
        if (k !== n) begin
            fails++;
            $display("FAIL send_bytes: accepted %0d bytes, required %0d", k, n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (bus.byte_ready !== 1'b0) begin fails++; $display("FAIL reset byte_ready: got %b want 0", bus.byte_ready); end
        tests++; if (bus.row_data !== '0) begin fails++; $display("FAIL reset row_data: got %h want 0", bus.row_data); end
        tests++; if ({bus.row_data_panel_addr, bus.row_data_row_addr} !== 6'd0) begin fails++; $display("FAIL reset addr: got %h want 0", {bus.row_data_panel_addr, bus.row_data_row_addr}); end
        tests++; if ({bus.row_data_write_enable, bus.busy, bus.frame_done, bus.frame_abort} !== 4'b0) begin fails++; $display("FAIL reset flags: got %b want 0000", {bus.row_data_write_enable, bus.busy, bus.frame_done, bus.frame_abort}); end
    endtask

    task automatic test_idle_bytes();
        int base = nw;
        int bad = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.byte_valid = 1'b1;
            bus.byte_in = 8'(8'hA5 + i);
            #1;
            if (bus.byte_ready !== 1'b0) bad++;
        end
        @(negedge clk);
        bus.byte_valid = 1'b0;
        #1;
        tests++; if (bad !== 0) begin fails++; $display("FAIL idle byte_ready: high %0d cycles, want 0", bad); end
        tests++; if (nw - base !== 0) begin fails++; $display("FAIL idle strobe: got %0d writes want 0", nw - base); end
        tests++; if (bus.row_data !== '0) begin fails++; $display("FAIL idle row_data: got %h want 0", bus.row_data); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL idle busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_full_frame();
        int base = nw;
        int d0 = ndone;
        do_reset();
        start_frame();
        #1;
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL full busy: got %b want 1", bus.busy); end
        send_bytes(3072, 0, 100);
        @(negedge clk);
        bus.byte_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        tests++; if (nw - base !== 64) begin fails++; $display("FAIL full writes: got %0d want 64", nw - base); end
        for (int w = 0; w < 64; w++) begin
            tests++; if (log_addr[base+w] !== 6'(w)) begin fails++; $display("FAIL full addr %0d: got %h want %h", w, log_addr[base+w], 6'(w)); end
            tests++; if (log_data[base+w] !== exp_row(48*w)) begin fails++; $display("FAIL full data %0d: got %h want %h", w, log_data[base+w], exp_row(48*w)); end
            if (w > 0) begin
                tests++; if (log_cyc[base+w] - log_cyc[base+w-1] !== 49) begin fails++; $display("FAIL full spacing %0d: got %0d want 49", w, log_cyc[base+w] - log_cyc[base+w-1]); end
            end
        end
        tests++; if (log_data[base][383:376] !== 8'h00) begin fails++; $display("FAIL full first byte: got %h want 00", log_data[base][383:376]); end
        tests++; if (log_data[base][7:0] !== 8'h2F) begin fails++; $display("FAIL full last byte: got %h want 2f", log_data[base][7:0]); end
        tests++; if (ndone - d0 !== 1) begin fails++; $display("FAIL full done count: got %0d want 1", ndone - d0); end
        tests++; if (done_cyc !== log_cyc[base+63] + 1) begin fails++; $display("FAIL full done timing: got cycle %0d want %0d", done_cyc, log_cyc[base+63] + 1); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL full busy after: got %b want 0", bus.busy); end
    endtask

    task automatic test_throttled();
        int base = nw;
        int v0 = viol;
        int d0 = ndone;
        do_reset();
        start_frame();
        send_bytes(3072, 0, 30);
        @(negedge clk);
        bus.byte_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        tests++; if (nw - base !== 64) begin fails++; $display("FAIL thr writes: got %0d want 64", nw - base); end
        for (int w = 0; w < 64; w++) begin
            tests++; if (log_addr[base+w] !== 6'(w)) begin fails++; $display("FAIL thr addr %0d: got %h want %h", w, log_addr[base+w], 6'(w)); end
            tests++; if (log_data[base+w] !== exp_row(48*w)) begin fails++; $display("FAIL thr data %0d: got %h want %h", w, log_data[base+w], exp_row(48*w)); end
        end
        tests++; if (viol - v0 !== 0) begin fails++; $display("FAIL thr ready in idle/write: got %0d cycles want 0", viol - v0); end
        tests++; if (ndone - d0 !== 1) begin fails++; $display("FAIL thr done count: got %0d want 1", ndone - d0); end
    endtask

    task automatic test_abort_mid_row();
        int base = nw;
        int a0 = nabort;
        do_reset();
        start_frame();
        send_bytes(21*48 + 20, 0, 100);
        @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_in = 8'hEE;
        bus.frame_start = 1'b1;
        #1;
        tests++; if (bus.byte_ready !== 1'b0) begin fails++; $display("FAIL abort byte_ready: got %b want 0", bus.byte_ready); end
        @(negedge clk);
        bus.frame_start = 1'b0;
        bus.byte_valid = 1'b0;
        #1;
        tests++; if (bus.frame_abort !== 1'b1) begin fails++; $display("FAIL abort pulse: got %b want 1", bus.frame_abort); end
        tests++; if ({bus.row_data_panel_addr, bus.row_data_row_addr} !== 6'd0) begin fails++; $display("FAIL abort addr: got %h want 0", {bus.row_data_panel_addr, bus.row_data_row_addr}); end
        tests++; if (nw - base !== 21) begin fails++; $display("FAIL abort no strobe: got %0d writes want 21", nw - base); end
        send_bytes(48, 8'h80, 100);
        @(negedge clk);
        bus.byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        tests++; if (nw - base !== 22) begin fails++; $display("FAIL abort next write count: got %0d want 22", nw - base); end
        tests++; if (log_addr[base+21] !== 6'd0) begin fails++; $display("FAIL abort next addr: got %h want 00", log_addr[base+21]); end
        tests++; if (log_data[base+21] !== exp_row(8'h80)) begin fails++; $display("FAIL abort next data: got %h want %h", log_data[base+21], exp_row(8'h80)); end
        tests++; if (nabort - a0 !== 1) begin fails++; $display("FAIL abort count: got %0d want 1", nabort - a0); end
    endtask

    task automatic test_start_on_write();
        int base = nw;
        int a0 = nabort;
        do_reset();
        start_frame();
        send_bytes(40*48, 0, 100);
        @(negedge clk);
        bus.frame_start = 1'b1;
        bus.byte_valid = 1'b0;
        #1;
        tests++; if (bus.row_data_write_enable !== 1'b1) begin fails++; $display("FAIL sow strobe: got %b want 1", bus.row_data_write_enable); end
        tests++; if ({bus.row_data_panel_addr, bus.row_data_row_addr} !== 6'd39) begin fails++; $display("FAIL sow addr: got %h want 27", {bus.row_data_panel_addr, bus.row_data_row_addr}); end
        @(negedge clk);
        bus.frame_start = 1'b0;
        #1;
        tests++; if (bus.frame_abort !== 1'b1) begin fails++; $display("FAIL sow abort: got %b want 1", bus.frame_abort); end
        tests++; if ({bus.row_data_panel_addr, bus.row_data_row_addr} !== 6'd0) begin fails++; $display("FAIL sow addr reset: got %h want 0", {bus.row_data_panel_addr, bus.row_data_row_addr}); end
        send_bytes(48, 8'hC0, 100);
        @(negedge clk);
        bus.byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        tests++; if (nw - base !== 41) begin fails++; $display("FAIL sow write count: got %0d want 41", nw - base); end
        tests++; if (log_addr[base+39] !== 6'd39) begin fails++; $display("FAIL sow logged addr: got %h want 27", log_addr[base+39]); end
        tests++; if (log_addr[base+40] !== 6'd0) begin fails++; $display("FAIL sow next addr: got %h want 00", log_addr[base+40]); end
        tests++; if (log_data[base+40] !== exp_row(8'hC0)) begin fails++; $display("FAIL sow next data: got %h want %h", log_data[base+40], exp_row(8'hC0)); end
        tests++; if (nabort - a0 !== 1) begin fails++; $display("FAIL sow abort count: got %0d want 1", nabort - a0); end
    endtask

    task automatic test_start_on_last();
        int a0 = nabort;
        int d0 = ndone;
        do_reset();
        start_frame();
        send_bytes(3072, 0, 100);
        @(negedge clk);
        bus.frame_start = 1'b1;
        bus.byte_valid = 1'b0;
        #1;
        tests++; if ({bus.row_data_write_enable, bus.row_data_panel_addr, bus.row_data_row_addr} !== 7'h7F) begin fails++; $display("FAIL sol last write: got %h want 7f", {bus.row_data_write_enable, bus.row_data_panel_addr, bus.row_data_row_addr}); end
        @(negedge clk);
        bus.frame_start = 1'b0;
        #1;
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL sol busy: got %b want 1", bus.busy); end
        repeat (3) @(negedge clk);
        #1;
        tests++; if (nabort - a0 !== 0) begin fails++; $display("FAIL sol abort: got %0d want 0", nabort - a0); end
        tests++; if (ndone - d0 !== 0) begin fails++; $display("FAIL sol done: got %0d want 0", ndone - d0); end
    endtask

    task automatic test_reset_mid_frame();
        int base = nw;
        int d0 = ndone;
        do_reset();
        start_frame();
        send_bytes(63*48 + 10, 0, 100);
        @(negedge clk);
        bus.byte_valid = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        tests++; if (bus.byte_ready !== 1'b0) begin fails++; $display("FAIL rst byte_ready: got %b want 0", bus.byte_ready); end
        tests++; if (bus.row_data !== '0) begin fails++; $display("FAIL rst row_data: got %h want 0", bus.row_data); end
        tests++; if ({bus.row_data_panel_addr, bus.row_data_row_addr} !== 6'd0) begin fails++; $display("FAIL rst addr: got %h want 0", {bus.row_data_panel_addr, bus.row_data_row_addr}); end
        tests++; if ({bus.row_data_write_enable, bus.busy, bus.frame_done, bus.frame_abort} !== 4'b0) begin fails++; $display("FAIL rst flags: got %b want 0000", {bus.row_data_write_enable, bus.busy, bus.frame_done, bus.frame_abort}); end
        repeat (3) @(negedge clk);
        bus.byte_valid = 1'b0;
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        tests++; if (nw - base !== 63) begin fails++; $display("FAIL rst writes: got %0d want 63", nw - base); end
        tests++; if (ndone - d0 !== 0) begin fails++; $display("FAIL rst done: got %0d want 0", ndone - d0); end
    endtask

    initial begin
        test_reset();
        test_idle_bytes();
        test_full_frame();
        test_throttled();
        test_abort_mid_row();
        test_start_on_write();
        test_start_on_last();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/frame_loader.md
Name: frame_loader

Overview:
- Receives a host byte stream (valid/ready) and assembles 48-byte rows.
- Sequences each assembled row into the LED controller's row-buffer write port: row_data, row/panel address, write enable.
- Walks panel 0..3 × row 0..15, so one frame = 64 row writes = 3072 bytes.
- Sits between the host interface and the LED controller; the only writer of the controller's row buffers.

Parameters:
- BYTES_PER_ROW, 48, bytes per row write; row_data width = 8*BYTES_PER_ROW.
- ROWS_PER_PANEL, 16, rows per panel; row address width 4.
- PANELS, 4, panels per frame; panel address width 2.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- frame_start  input  1  one-cycle pulse: begin (or restart) a frame at panel 0, row 0, byte 0
- byte_in  input  8  stream data
- byte_valid  input  1  byte_in valid
- byte_ready  output  1  loader accepts a byte this cycle when byte_valid & byte_ready
- row_data  output  384  assembled row; first byte of row in [383:376], last byte in [7:0]
- row_data_row_addr  output  4  target row of the current write
- row_data_panel_addr  output  2  target panel of the current write
- row_data_write_enable  output  1  one-cycle row write strobe
- busy  output  1  high while a frame is in progress (COLLECT or WRITE)
- frame_done  output  1  one-cycle pulse after the 64th write
- frame_abort  output  1  one-cycle pulse when frame_start arrives mid-frame

Behaviour:
- Reset (async, reset_n low), all outputs registered:
  - state=IDLE; byte_ready=0; row_data=0; addresses=0; byte counter=0.
  - row_data_write_enable=0; busy=0; frame_done=0; frame_abort=0.
- States:
  - IDLE: byte_ready=0; bytes are ignored. frame_start -> COLLECT with counters cleared.
  - COLLECT: byte_ready=1.
    - Each accepted byte: row_data <= {row_data[375:0], byte_in}; byte counter +1.
    - Gaps in byte_valid are allowed with no timeout.
    - When the 48th byte is accepted (counter = 47 & accept): counter <= 0, state -> WRITE.
  - WRITE (exactly one cycle):
    - row_data_write_enable=1; byte_ready=0.
    - row_data and addresses are stable and equal to the values just assembled and targeted.
    - Next cycle: row+1. On row 15, wrap to 0 and panel+1.
    - After panel 3 row 15: addresses -> 0, frame_done pulses the following cycle, state -> IDLE.
    - Otherwise -> COLLECT.
- Latency: the write strobe asserts the cycle after the 48th byte is accepted. Minimum 49 cycles per row; 3136 cycles per frame at full rate.
- Write order is panel-major: p0 r0..r15, p1 r0..r15, …, p3 r15.
- Addresses change only in the cycle after a WRITE, on frame_start, or on reset.
- busy=1 in COLLECT and WRITE; 0 in IDLE (including the frame_done cycle).
- frame_start in COLLECT:
  - Partial row is discarded; counters and addresses cleared.
  - A byte presented in the same cycle is NOT accepted (byte_ready deasserted that cycle).
  - frame_abort pulses next cycle; stays in COLLECT.
- frame_start in WRITE:
  - The write in progress still completes with its original address.
  - Position then resets to p0 r0 byte 0; frame_abort pulses; next state COLLECT.
  - If that write was the 64th, frame_done is suppressed and frame_abort is not asserted (treated as a clean new frame).
- frame_start in IDLE: no abort pulse.
- row_data is not cleared between rows; stale bits are fully overwritten by the 48 shifts.
- Reset mid-frame: immediate return to reset values; no write strobe issued.

Test Plan:
- Full frame: frame_start, then 3072 bytes at full rate, byte k = k mod 256.
  - Expect 64 strobes in order p0r0..p3r15, one every 49 cycles.
  - First write: row_data[383:376]=0x00, [7:0]=0x2F.
  - frame_done exactly one cycle after the 64th strobe; busy low thereafter.
- Throttled stream: byte_valid random 30% duty over one frame.
  - Same 64 writes and data as the full-frame test; byte_ready never high in IDLE or WRITE.
- Abort mid-row: frame_start after 20 bytes of p1r5.
  - No strobe; frame_abort=1 one cycle later.
  - The next 48 bytes produce a write to p0r0 containing only those bytes.
- frame_start coincident with a WRITE cycle (p2r7).
  - That write completes at p2r7.
  - frame_abort pulses; the next write targets p0r0.
- Bytes with byte_valid=1 before any frame_start: byte_ready=0, no strobe, row_data remains 0.
- reset_n asserted during p3r15 collection: all outputs return to reset values asynchronously; no frame_done.
